// File: rtl/rsv_multi_wakeup.sv
// Reservation station for one functional unit: SIZE entries, NUM_WK wakeup ports, registered issue stage.
// Define RSV_AGE_ORDER_EN for oldest-first issue through an age matrix; otherwise the lowest ready index issues.
module rsv_multi_wakeup #(
   parameter int XLEN          = 32,
   parameter int SIZE          = 16,
   parameter int PHYS_REG_SIZE = 256,
   parameter int ROB_SIZE      = 256,
   parameter int NUM_WK        = 2,
   localparam int TAGW         = $clog2(PHYS_REG_SIZE),
   localparam int ROBW         = $clog2(ROB_SIZE),
   localparam int CNTW         = $clog2(SIZE + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   valid_in,
   output logic                   in_ready,
   input  logic [ROBW-1:0]        rob_entry_in,
   input  logic [TAGW-1:0]        rs1_reg,
   input  logic [TAGW-1:0]        rs2_reg,
   input  logic                   rs1_received,
   input  logic                   rs2_received,
   input  logic [XLEN-1:0]        rs1_value,
   input  logic [XLEN-1:0]        rs2_value,
   input  logic [XLEN-1:0]        pc_in,
   input  logic [4:0]             opcode_in,
   input  logic [2:0]             opcode_type_in,
   input  logic                   additional_info_in,
   input  logic [NUM_WK-1:0]      wk_valid,
   input  logic [NUM_WK*TAGW-1:0] wk_tag,
   input  logic [NUM_WK*XLEN-1:0] wk_val,
   output logic                   valid_out,
   input  logic                   fu_ready,
   output logic [ROBW-1:0]        rob_entry,
   output logic [XLEN-1:0]        rs1,
   output logic [XLEN-1:0]        rs2,
   output logic [XLEN-1:0]        pc,
   output logic [4:0]             opcode,
   output logic [2:0]             opcode_type,
   output logic                   additional_info,
   output logic [CNTW-1:0]        count
);

   localparam int IDXW = (SIZE > 1) ? $clog2(SIZE) : 1;

   logic [SIZE-1:0] vld_q, vld_d, r1_rcv_q, r1_rcv_d, r2_rcv_q, r2_rcv_d, add_q, add_d;
   logic [ROBW-1:0] rob_q    [SIZE];
   logic [ROBW-1:0] rob_d    [SIZE];
   logic [TAGW-1:0] r1_tag_q [SIZE];
   logic [TAGW-1:0] r1_tag_d [SIZE];
   logic [TAGW-1:0] r2_tag_q [SIZE];
   logic [TAGW-1:0] r2_tag_d [SIZE];
   logic [XLEN-1:0] r1_val_q [SIZE];
   logic [XLEN-1:0] r1_val_d [SIZE];
   logic [XLEN-1:0] r2_val_q [SIZE];
   logic [XLEN-1:0] r2_val_d [SIZE];
   logic [XLEN-1:0] pc_q     [SIZE];
   logic [XLEN-1:0] pc_d     [SIZE];
   logic [4:0]      opc_q    [SIZE];
   logic [4:0]      opc_d    [SIZE];
   logic [2:0]      opt_q    [SIZE];
   logic [2:0]      opt_d    [SIZE];

   logic            out_vld_q, out_vld_d, out_add_q, out_add_d;
   logic [ROBW-1:0] out_rob_q, out_rob_d;
   logic [XLEN-1:0] out_rs1_q, out_rs1_d, out_rs2_q, out_rs2_d, out_pc_q, out_pc_d;
   logic [4:0]      out_opc_q, out_opc_d;
   logic [2:0]      out_opt_q, out_opt_d;
   logic [CNTW-1:0] count_q, count_d;

   logic [SIZE-1:0] rdy, oldest;
   logic            any_rdy, alloc, issue;
   logic [IDXW-1:0] free_idx, sel_idx;

   // Returns {hit, value}; scanning from the top port down lets the lowest port index win.
   function automatic logic [XLEN:0] wk_lookup(input logic [TAGW-1:0] tag,
                                               input logic [NUM_WK-1:0] v,
                                               input logic [NUM_WK*TAGW-1:0] t,
                                               input logic [NUM_WK*XLEN-1:0] d);
      logic [XLEN:0] r;
      r = '0;
      for (int p = NUM_WK - 1; p >= 0; p--) begin
         if (v[p] && (t[p*TAGW +: TAGW] == tag)) r = {1'b1, d[p*XLEN +: XLEN]};
      end
      return r;
   endfunction

   assign rdy      = vld_q & r1_rcv_q & r2_rcv_q;
   assign any_rdy  = |rdy;
   assign in_ready = ~&vld_q;
   assign alloc    = valid_in & in_ready & ~flush;
   assign issue    = (~out_vld_q | fu_ready) & any_rdy;

   always_comb begin
      free_idx = '0;
      for (int i = SIZE - 1; i >= 0; i--) begin
         if (!vld_q[i]) free_idx = IDXW'(i);
      end
   end

`ifdef RSV_AGE_ORDER_EN
   // age_q[i][j] set means entry j was allocated before entry i.
   logic [SIZE-1:0] age_q [SIZE];
   logic [SIZE-1:0] age_d [SIZE];

   always_comb begin
      for (int i = 0; i < SIZE; i++) oldest[i] = rdy[i] & ~|(age_q[i] & rdy);
   end

   always_comb begin
      age_d = age_q;
      if (alloc) begin
         for (int i = 0; i < SIZE; i++) age_d[i][free_idx] = 1'b0;
         age_d[free_idx] = vld_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SIZE; i++) age_q[i] <= '0;
      end else begin
         age_q <= age_d;
      end
   end
`else
   assign oldest = rdy;
`endif

   always_comb begin
      sel_idx = '0;
      for (int i = SIZE - 1; i >= 0; i--) begin
         if (oldest[i]) sel_idx = IDXW'(i);
      end
   end

   always_comb begin
      logic [XLEN:0] w1, w2;
      w1       = '0;
      w2       = '0;
      vld_d    = vld_q;
      r1_rcv_d = r1_rcv_q;
      r2_rcv_d = r2_rcv_q;
      add_d    = add_q;
      rob_d    = rob_q;
      r1_tag_d = r1_tag_q;
      r2_tag_d = r2_tag_q;
      r1_val_d = r1_val_q;
      r2_val_d = r2_val_q;
      pc_d     = pc_q;
      opc_d    = opc_q;
      opt_d    = opt_q;
      for (int i = 0; i < SIZE; i++) begin
         if (vld_q[i] && !r1_rcv_q[i]) begin
            w1 = wk_lookup(r1_tag_q[i], wk_valid, wk_tag, wk_val);
            if (w1[XLEN]) begin
               r1_rcv_d[i] = 1'b1;
               r1_val_d[i] = w1[XLEN-1:0];
            end
         end
         if (vld_q[i] && !r2_rcv_q[i]) begin
            w2 = wk_lookup(r2_tag_q[i], wk_valid, wk_tag, wk_val);
            if (w2[XLEN]) begin
               r2_rcv_d[i] = 1'b1;
               r2_val_d[i] = w2[XLEN-1:0];
            end
         end
      end
      if (issue) vld_d[sel_idx] = 1'b0;
      if (alloc) begin
         vld_d[free_idx]    = 1'b1;
         rob_d[free_idx]    = rob_entry_in;
         r1_tag_d[free_idx] = rs1_reg;
         r2_tag_d[free_idx] = rs2_reg;
         pc_d[free_idx]     = pc_in;
         opc_d[free_idx]    = opcode_in;
         opt_d[free_idx]    = opcode_type_in;
         add_d[free_idx]    = additional_info_in;
         r1_rcv_d[free_idx] = rs1_received;
         r1_val_d[free_idx] = rs1_value;
         r2_rcv_d[free_idx] = rs2_received;
         r2_val_d[free_idx] = rs2_value;
         // Same-cycle bypass so a source broadcast during dispatch is not missed.
         if (!rs1_received) begin
            w1 = wk_lookup(rs1_reg, wk_valid, wk_tag, wk_val);
            if (w1[XLEN]) begin
               r1_rcv_d[free_idx] = 1'b1;
               r1_val_d[free_idx] = w1[XLEN-1:0];
            end
         end
         if (!rs2_received) begin
            w2 = wk_lookup(rs2_reg, wk_valid, wk_tag, wk_val);
            if (w2[XLEN]) begin
               r2_rcv_d[free_idx] = 1'b1;
               r2_val_d[free_idx] = w2[XLEN-1:0];
            end
         end
      end
      if (flush) vld_d = '0;
   end

   always_comb begin
      out_vld_d = out_vld_q;
      out_rob_d = out_rob_q;
      out_rs1_d = out_rs1_q;
      out_rs2_d = out_rs2_q;
      out_pc_d  = out_pc_q;
      out_opc_d = out_opc_q;
      out_opt_d = out_opt_q;
      out_add_d = out_add_q;
      if (!out_vld_q || fu_ready) begin
         out_vld_d = any_rdy;
         if (any_rdy) begin
            out_rob_d = rob_q[sel_idx];
            out_rs1_d = r1_val_q[sel_idx];
            out_rs2_d = r2_val_q[sel_idx];
            out_pc_d  = pc_q[sel_idx];
            out_opc_d = opc_q[sel_idx];
            out_opt_d = opt_q[sel_idx];
            out_add_d = add_q[sel_idx];
         end
      end
      count_d = count_q + CNTW'(alloc) - CNTW'(issue);
      if (flush) begin
         out_vld_d = 1'b0;
         count_d   = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q     <= '0;
         r1_rcv_q  <= '0;
         r2_rcv_q  <= '0;
         add_q     <= '0;
         for (int i = 0; i < SIZE; i++) begin
            rob_q[i]    <= '0;
            r1_tag_q[i] <= '0;
            r2_tag_q[i] <= '0;
            r1_val_q[i] <= '0;
            r2_val_q[i] <= '0;
            pc_q[i]     <= '0;
            opc_q[i]    <= '0;
            opt_q[i]    <= '0;
         end
         out_vld_q <= 1'b0;
         out_rob_q <= '0;
         out_rs1_q <= '0;
         out_rs2_q <= '0;
         out_pc_q  <= '0;
         out_opc_q <= '0;
         out_opt_q <= '0;
         out_add_q <= 1'b0;
         count_q   <= '0;
      end else begin
         vld_q     <= vld_d;
         r1_rcv_q  <= r1_rcv_d;
         r2_rcv_q  <= r2_rcv_d;
         add_q     <= add_d;
         rob_q     <= rob_d;
         r1_tag_q  <= r1_tag_d;
         r2_tag_q  <= r2_tag_d;
         r1_val_q  <= r1_val_d;
         r2_val_q  <= r2_val_d;
         pc_q      <= pc_d;
         opc_q     <= opc_d;
         opt_q     <= opt_d;
         out_vld_q <= out_vld_d;
         out_rob_q <= out_rob_d;
         out_rs1_q <= out_rs1_d;
         out_rs2_q <= out_rs2_d;
         out_pc_q  <= out_pc_d;
         out_opc_q <= out_opc_d;
         out_opt_q <= out_opt_d;
         out_add_q <= out_add_d;
         count_q   <= count_d;
      end
   end

   assign valid_out       = out_vld_q;
   assign rob_entry       = out_rob_q;
   assign rs1             = out_rs1_q;
   assign rs2             = out_rs2_q;
   assign pc              = out_pc_q;
   assign opcode          = out_opc_q;
   assign opcode_type     = out_opt_q;
   assign additional_info = out_add_q;
   assign count           = count_q;

endmodule
